// File: rtl/sd_access_pkg.sv
// Shared FSM encoding and big-endian byte-lane helpers for sd_access_cache.
package sd_access_pkg;

    typedef enum logic [1:0] {
        s_idle      = 2'd0,
        s_wait_idle = 2'd1,
        s_wait_rd   = 2'd2
    } state_t;

    // Byte offset 0 lives in the most significant lane of a line.
    function automatic int lane_of(input int line_bytes, input int offset);
        return line_bytes - 1 - offset;
    endfunction

    function automatic logic lane_mask(input int line_bytes, input int offset, input int lane);
        return lane == lane_of(line_bytes, offset);
    endfunction

endpackage

// File: rtl/sd_access_cache_if.sv
// TV80 bus and scoreboard request/response channels seen by sd_access_cache.
interface sd_access_cache_if #(
    parameter int z_asz      = 14,
    parameter int line_bytes = 8
);
    localparam int lb    = $clog2(line_bytes);
    localparam int s_asz = z_asz - lb;
    localparam int lw    = 8 * line_bytes;

    logic             flush;
    logic             ack;
    logic             mreq_n;
    logic             cs_n;
    logic             rd_n;
    logic             wr_n;
    logic [z_asz-1:0] addr;
    logic [7:0]       wr_data;
    logic [7:0]       rd_data;
    logic             z2s_srdy;
    logic             z2s_drdy;
    logic             z2s_req_type;
    logic [lw-1:0]    z2s_mask;
    logic [lw-1:0]    z2s_data;
    logic [s_asz-1:0] z2s_itemid;
    logic             s2z_srdy;
    logic             s2z_drdy;
    logic [lw-1:0]    s2z_data;

    modport master (
        output flush, mreq_n, cs_n, rd_n, wr_n, addr, wr_data, z2s_drdy, s2z_srdy, s2z_data,
        input  ack, rd_data, z2s_srdy, z2s_req_type, z2s_mask, z2s_data, z2s_itemid, s2z_drdy
    );

    modport slave (
        input  flush, mreq_n, cs_n, rd_n, wr_n, addr, wr_data, z2s_drdy, s2z_srdy, s2z_data,
        output ack, rd_data, z2s_srdy, z2s_req_type, z2s_mask, z2s_data, z2s_itemid, s2z_drdy
    );

endinterface

// File: rtl/sd_line_store.sv
// Direct-mapped tag/valid/line register array with fill, byte-write and flush.
module sd_line_store #(
    parameter int nent = 4,
    parameter int ib   = 2,
    parameter int tw   = 9,
    parameter int lw   = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic [ib-1:0] idx,
    output logic          rd_valid,
    output logic [tw-1:0] rd_tag,
    output logic [lw-1:0] rd_line,
    input  logic          fill_en,
    input  logic [tw-1:0] fill_tag,
    input  logic [lw-1:0] fill_line,
    input  logic          bw_en,
    input  logic [lw-1:0] bw_mask,
    input  logic [lw-1:0] bw_data
);

    logic [nent-1:0] valid;
    logic [tw-1:0]   tag_mem  [nent];
    logic [lw-1:0]   line_mem [nent];

    assign rd_valid = valid[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = line_mem[idx];

    // Flush beats a same-cycle fill so a flushed fill leaves the entry invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            for (int i = 0; i < nent; i++) begin
                tag_mem[i]  <= '0;
                line_mem[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid <= '0;
            end else if (fill_en) begin
                valid[idx] <= 1'b1;
            end
            if (fill_en) begin
                tag_mem[idx]  <= fill_tag;
                line_mem[idx] <= fill_line;
            end else if (bw_en) begin
                line_mem[idx] <= (line_mem[idx] & ~bw_mask) | (bw_data & bw_mask);
            end
        end
    end

endmodule

// File: rtl/sd_access_cache.sv
// TV80-to-scoreboard access bridge with a direct-mapped write-through line cache.
// Define SD_ACCESS_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module sd_access_cache
    import sd_access_pkg::*;
#(
    parameter int z_asz      = 14,
    parameter int line_bytes = 8,
    parameter int nlines     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef SD_ACCESS_STATS_EN
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
`endif
    sd_access_cache_if.slave bus
);

    localparam int lb    = $clog2(line_bytes);
    localparam int s_asz = z_asz - lb;
    localparam int ib    = (nlines > 1) ? $clog2(nlines) : 1;
    localparam int nent  = 1 << ib;
    localparam int tw    = z_asz - lb - ib;
    localparam int lw    = 8 * line_bytes;

    state_t              state;
    logic                ack_q;
    logic                bus_act, rd_acc, wr_acc, hit;
    logic                fill_en, bw_en;
    logic [ib-1:0]       idx;
    logic [tw-1:0]       tag;
    logic [lb-1:0]       offset;
    logic [s_asz-1:0]    itemid;
    logic                line_valid;
    logic [tw-1:0]       line_tag;
    logic [lw-1:0]       line_data;
    logic [line_bytes-1:0] lane_sel;
    logic [lw-1:0]       wmask;
    logic [7:0]          rd_byte;

    assign idx     = bus.addr[lb+ib-1:lb];
    assign tag     = bus.addr[z_asz-1:lb+ib];
    assign offset  = bus.addr[lb-1:0];
    assign itemid  = bus.addr[z_asz-1:lb];

    // Write wins when both strobes are low.
    assign bus_act = !bus.mreq_n && !bus.cs_n;
    assign wr_acc  = bus_act && !bus.wr_n;
    assign rd_acc  = bus_act && !bus.rd_n && bus.wr_n;
    assign hit     = line_valid && (line_tag == tag);

    for (genvar b = 0; b < line_bytes; b++) begin : g_lane
        assign lane_sel[b] = lane_mask(line_bytes, int'(offset), b);
    end

    always_comb begin
        rd_byte = 8'h00;
        wmask   = '0;
        for (int b = 0; b < line_bytes; b++) begin
            if (lane_sel[b]) begin
                rd_byte = line_data[8*b +: 8];
            end
            wmask[8*b +: 8] = {8{lane_sel[b] & wr_acc}};
        end
    end

    assign bus.rd_data      = rd_byte;
    assign bus.ack          = ack_q;
    assign bus.z2s_srdy     = (state == s_idle) && (wr_acc || (rd_acc && !hit));
    assign bus.z2s_req_type = wr_acc;
    assign bus.z2s_mask     = wmask;
    assign bus.z2s_data     = {line_bytes{bus.wr_data}};
    assign bus.z2s_itemid   = itemid;
    assign bus.s2z_drdy     = (state == s_wait_rd);

    assign fill_en = (state == s_wait_rd) && bus.s2z_srdy;
    assign bw_en   = (state == s_idle) && wr_acc && bus.z2s_drdy && hit;

    sd_line_store #(
        .nent (nent),
        .ib   (ib),
        .tw   (tw),
        .lw   (lw)
    ) u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.flush),
        .idx       (idx),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_line   (line_data),
        .fill_en   (fill_en),
        .fill_tag  (tag),
        .fill_line (bus.s2z_data),
        .bw_en     (bw_en),
        .bw_mask   (wmask),
        .bw_data   (bus.z2s_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= s_idle;
            ack_q <= 1'b0;
        end else begin
            case (state)
                s_idle: begin
                    if (wr_acc) begin
                        if (bus.z2s_drdy) begin
                            ack_q <= 1'b1;
                            state <= s_wait_idle;
                        end
                    end else if (rd_acc) begin
                        if (hit) begin
                            ack_q <= 1'b1;
                            state <= s_wait_idle;
                        end else if (bus.z2s_drdy) begin
                            state <= s_wait_rd;
                        end
                    end
                end
                s_wait_rd: begin
                    if (bus.s2z_srdy) begin
                        state <= s_idle;
                    end
                end
                s_wait_idle: begin
                    if (bus.mreq_n || bus.cs_n) begin
                        ack_q <= 1'b0;
                        state <= s_idle;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= s_idle;
                end
            endcase
        end
    end

`ifdef SD_ACCESS_STATS_EN
    logic hit_inc, miss_inc;

    assign hit_inc  = (state == s_idle) && rd_acc && hit;
    assign miss_inc = (state == s_idle) && rd_acc && !hit && bus.z2s_drdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else if (bus.flush) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (hit_inc && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (miss_inc && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sd_access_cache.sv
// Randomised self-checking bench for sd_access_cache against a line-level cache/memory model.
module tb_sd_access_cache;

    localparam int z_asz      = 14;
    localparam int line_bytes = 8;
    localparam int nlines     = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    logic [63:0] mem [2048];
    bit          mValid [nlines];
    int          mTag [nlines];
    int          mHits = 0;
    int          mMisses = 0;

    sd_access_cache_if #(.z_asz(z_asz), .line_bytes(line_bytes)) bus();

`ifdef SD_ACCESS_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    sd_access_cache #(
        .z_asz      (z_asz),
        .line_bytes (line_bytes),
        .nlines     (nlines)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef SD_ACCESS_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] memByte(input logic [13:0] a);
        logic [63:0] l;
        int off;
        l   = mem[int'(a >> 3)];
        off = int'(a % 14'd8);
        return l[8*(7-off) +: 8];
    endfunction

    task automatic releaseBus();
        bus.z2s_drdy = 1'b0;
        bus.s2z_srdy = 1'b0;
        bus.flush    = 1'b0;
        bus.mreq_n   = 1'b1;
        bus.cs_n     = 1'b1;
        bus.rd_n     = 1'b1;
        bus.wr_n     = 1'b1;
    endtask

    task automatic checkStats();
`ifdef SD_ACCESS_STATS_EN
        checkOutput("hitCnt", 64'(hit_cnt), 64'(mHits));
        checkOutput("missCnt", 64'(miss_cnt), 64'(mMisses));
`endif
    endtask

    // flushMode: 0 none, 1 random pulses, 2 flush on the first fill beat
    task automatic applyStimulus(input bit isWrite, input bit alsoRd, input logic [13:0] a,
                                 input logic [7:0] wd, input int stall, input int flushMode,
                                 input int expReqs, output logic [7:0] rdByte);
        int idx, tag, item, off, reqs, cyc, acceptCyc, stallLeft;
        bit expHit, done, prevFlush, fl, fill, flushedFill;
        logic [63:0] expMask, expData;
        idx       = int'(a >> 3) % nlines;
        tag       = int'(a >> 5);
        item      = int'(a >> 3);
        off       = int'(a % 14'd8);
        expHit    = mValid[idx] && (mTag[idx] == tag);
        expMask   = 64'hFF << (8*(line_bytes-1-off));
        expData   = {8{wd}};
        reqs      = 0;
        cyc       = 0;
        acceptCyc = -1;
        stallLeft = stall;
        done      = 0;
        prevFlush = 0;
        flushedFill = 0;
        rdByte    = 8'h00;

        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = wd;
        bus.mreq_n  = 1'b0;
        bus.cs_n    = 1'b0;
        bus.wr_n    = !isWrite;
        bus.rd_n    = isWrite ? !alsoRd : 1'b0;
        #1;
        while (!done && cyc < 60) begin
            if (bus.ack) begin
                done   = 1;
                rdByte = bus.rd_data;
                if (isWrite) begin
                    checkOutput("wrAckLat", 64'(cyc), 64'(acceptCyc + 1));
                end else begin
                    checkOutput("rdData", 64'(bus.rd_data), 64'(memByte(a)));
                    if (expHit) begin
                        checkOutput("hitLat", 64'(cyc), 64'd1);
                        checkOutput("hitNoReq", 64'(reqs), 64'd0);
                    end
                    if (!prevFlush) mHits++;
                end
                if (expReqs >= 0) checkOutput("reqCount", 64'(reqs), 64'(expReqs));
            end else begin
                fl   = 0;
                fill = 0;
                if (bus.z2s_srdy) begin
                    checkOutput("reqType", 64'(bus.z2s_req_type), 64'(isWrite));
                    checkOutput("itemId", 64'(bus.z2s_itemid), 64'(item));
                    checkOutput("reqMask", bus.z2s_mask, isWrite ? expMask : 64'd0);
                    if (isWrite) checkOutput("reqData", bus.z2s_data, expData);
                    if (stallLeft > 0) begin
                        bus.z2s_drdy = 1'b0;
                        stallLeft--;
                    end else begin
                        bus.z2s_drdy = 1'b1;
                        reqs++;
                        acceptCyc = cyc;
                        if (isWrite) mem[item] = (mem[item] & ~expMask) | (expData & expMask);
                        else mMisses++;
                    end
                end else begin
                    bus.z2s_drdy = 1'b0;
                end
                if (bus.s2z_drdy) begin
                    bus.s2z_data = mem[item];
                    bus.s2z_srdy = ($urandom_range(3, 0) != 0);
                    if (bus.s2z_srdy) begin
                        fill = 1;
                        if (flushMode == 2 && !flushedFill) begin
                            fl = 1;
                            flushedFill = 1;
                        end
                    end
                end else begin
                    bus.s2z_srdy = 1'b0;
                end
                if (flushMode == 1 && $urandom_range(15, 0) == 0) fl = 1;
                bus.flush = fl;
                if (fl) begin
                    for (int i = 0; i < nlines; i++) mValid[i] = 0;
                    mHits   = 0;
                    mMisses = 0;
                end else if (fill) begin
                    mValid[idx] = 1;
                    mTag[idx]   = tag;
                end
                prevFlush = fl;
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        if (!done) checkOutput("timeout", 64'd1, 64'd0);
        releaseBus();
        @(negedge clk);
        #1;
        checkOutput("ackDrop", 64'(bus.ack), 64'd0);
        checkStats();
    endtask

    initial begin
        logic [7:0] rb;
        logic [13:0] ra;
        for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < nlines; i++) begin
            mValid[i] = 0;
            mTag[i]   = 0;
        end
        bus.addr     = '0;
        bus.wr_data  = 8'h00;
        bus.s2z_data = '0;
        releaseBus();

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstAck", 64'(bus.ack), 64'd0);
        checkOutput("rstZ2sSrdy", 64'(bus.z2s_srdy), 64'd0);
        checkOutput("rstS2zDrdy", 64'(bus.s2z_drdy), 64'd0);
        reset_n = 1'b1;
        checkStats();

        // read miss, then hit in the same line
        mem[2] = 64'h0011223344556677;
        applyStimulus(0, 0, 14'h0012, 8'h00, 0, 0, 1, rb);
        checkOutput("tpMissByte", 64'(rb), 64'h22);
        applyStimulus(0, 0, 14'h0013, 8'h00, 0, 0, 0, rb);
        checkOutput("tpHitByte", 64'(rb), 64'h33);

        // write hit updates the cached byte
        applyStimulus(1, 0, 14'h0015, 8'hAB, 0, 0, 1, rb);
        applyStimulus(0, 0, 14'h0015, 8'h00, 0, 0, 0, rb);
        checkOutput("tpWrHitByte", 64'(rb), 64'hAB);

        // conflict eviction on idx 0
        applyStimulus(0, 0, 14'h0000, 8'h00, 0, 0, 1, rb);
        applyStimulus(0, 0, 14'h0020, 8'h00, 0, 0, 1, rb);
        applyStimulus(0, 0, 14'h0000, 8'h00, 0, 0, 1, rb);

        // backpressured write, with rd_n also low
        applyStimulus(1, 1, 14'h0003, 8'h5C, 5, 0, 1, rb);
        applyStimulus(0, 0, 14'h0003, 8'h00, 0, 0, 0, rb);
        checkOutput("tpBpByte", 64'(rb), 64'h5C);

        // flush coinciding with the fill forces a re-issue
        applyStimulus(0, 0, 14'h0108, 8'h00, 0, 2, 2, rb);
        applyStimulus(0, 0, 14'h0109, 8'h00, 0, 0, 0, rb);

        // reset while waiting for the response
        @(negedge clk);
        bus.addr   = 14'h0200;
        bus.mreq_n = 1'b0;
        bus.cs_n   = 1'b0;
        bus.rd_n   = 1'b0;
        #1;
        checkOutput("rstReqSeen", 64'(bus.z2s_srdy), 64'd1);
        bus.z2s_drdy = 1'b1;
        @(negedge clk);
        #1;
        bus.z2s_drdy = 1'b0;
        checkOutput("rstPreDrdy", 64'(bus.s2z_drdy), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rstMidAck", 64'(bus.ack), 64'd0);
        checkOutput("rstMidDrdy", 64'(bus.s2z_drdy), 64'd0);
        releaseBus();
        for (int i = 0; i < nlines; i++) mValid[i] = 0;
        mHits   = 0;
        mMisses = 0;
        @(negedge clk);
        #1;
        checkStats();
        reset_n = 1'b1;
        applyStimulus(0, 0, 14'h0013, 8'h00, 0, 0, 1, rb);
        applyStimulus(0, 0, 14'h0000, 8'h00, 0, 0, 1, rb);

        // randomised mix of reads, writes, stalls and flushes
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(9, 0) == 0) ra = 14'($urandom);
            else ra = 14'($urandom_range(0, 511));
            applyStimulus($urandom_range(2, 0) == 0, 1'($urandom_range(1, 0)), ra,
                          8'($urandom), $urandom_range(3, 0), 1, -1, rb);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
